act_ofifo: RTL

Output FIFO that collects quantized activations from the SFP stage and presents them to the readout path as full rows. Holds one independent FIFO lane per column: the SFP writes each lane with its own per-column valid bit. The readout reads a `col`-wide activation row only once every lane holds data. It sits directly downstream of the SFP and upstream of the activation readout/SRAM write path.

---
 rtl/act_ofifo_pkg.sv | 10 +
 rtl/ofifo_lane.sv | 53 +++++
 rtl/act_ofifo.sv | 75 +++++++
 3 files changed

// File: rtl/act_ofifo_pkg.sv
// Shared constants for the SFP / output-FIFO datapath.
// Lane and top-level defaults are taken from here so every stage agrees on widths.
package act_ofifo_pkg;

    localparam int PSUM_BW     = 16;
    localparam int ACT_BW      = 4;
    localparam int COL         = 8;
    localparam int OFIFO_DEPTH = 16;

endpackage

// File: rtl/ofifo_lane.sv
// One column of the output FIFO: a first-word-fall-through queue with
// wrap-bit pointers so that full and empty are distinguishable.
module ofifo_lane
    import act_ofifo_pkg::*;
#(
    parameter int act_bw = ACT_BW,
    parameter int depth  = OFIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [act_bw-1:0]          din,
    input  logic                       rd,
    output logic [act_bw-1:0]          dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(depth):0]     count,
    output logic                       wr_drop
);

    localparam int aw = $clog2(depth);

    logic [aw:0]       wptr;
    logic [aw:0]       rptr;
    logic [act_bw-1:0] mem [depth];

    assign empty   = (wptr == rptr);
    assign full    = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
    // Subtraction wraps modulo 2*depth because the pointers carry one extra bit.
    assign count   = wptr - rptr;
    assign wr_drop = wr && full;
    assign dout    = mem[rptr[aw-1:0]];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr && !full) wptr <= wptr + 1'b1;
            // The top only asserts rd when this lane is non-empty.
            if (rd)          rptr <= rptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone
    // define validity, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr && !full) mem[wptr[aw-1:0]] <= din;
    end

endmodule

// File: rtl/act_ofifo.sv
// Output FIFO collecting SFP activations per column and releasing them to the
// readout path only as complete rows.
module act_ofifo
    import act_ofifo_pkg::*;
#(
    parameter int col    = COL,
    parameter int act_bw = ACT_BW,
    parameter int depth  = OFIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [col*act_bw-1:0]      act_in,
    input  logic [col-1:0]             act_valid,
    input  logic                       rd,
    output logic [col*act_bw-1:0]      out,
    output logic                       o_valid,
    output logic                       o_full,
    output logic                       o_ready,
    output logic                       overflow,
    output logic                       underflow,
    output logic [$clog2(depth):0]     row_count
);

    localparam int cw = $clog2(depth) + 1;

    logic [col-1:0] lane_empty;
    logic [col-1:0] lane_full;
    logic [col-1:0] lane_drop;
    logic [cw-1:0]  lane_count [col];
    logic           pop;

    assign o_valid = ~|lane_empty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    // Lanes advance in lockstep, and only when a whole row is present.
    assign pop     = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(
            .act_bw (act_bw),
            .depth  (depth)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .wr      (act_valid[i]),
            .din     (act_in[i*act_bw +: act_bw]),
            .rd      (pop),
            .dout    (out[i*act_bw +: act_bw]),
            .empty   (lane_empty[i]),
            .full    (lane_full[i]),
            .count   (lane_count[i]),
            .wr_drop (lane_drop[i])
        );
    end

    // NOTE: the running minimum is seeded before the loop so row_count is
    // assigned on every path and no latch is inferred.
    always_comb begin
        row_count = lane_count[0];
        for (int i = 1; i < col; i++) begin
            if (lane_count[i] < row_count) row_count = lane_count[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (|lane_drop)        overflow  <= 1'b1;
            if (rd && !o_valid)    underflow <= 1'b1;
        end
    end

endmodule
